draw_sprite: RTL
================

// Module: draw_sprite
// PURPOSE
//  Overlays a SPR_W x SPR_H image, fetched from an external synchronous pixel ROM, onto the
//  vga_if stream at position (xpos,ypos); all other pixels pass through unchanged.
//  Sits between the background/draw stages and the VGA output, and matches any ROM read
//  latency by delaying the timing signals.
//  Position and enable are latched once per frame, so a sprite is never torn mid-frame.
// PARAMETERS
//  SPR_W     48      sprite width in pixels, 1..2**ADDR_X_W
//  SPR_H     64      sprite height in pixels, 1..2**ADDR_Y_W
//  ADDR_X_W  6       column-address bits in pixel_addr
//  ADDR_Y_W  6       row-address bits in pixel_addr
//  ROM_LAT   1       clk cycles from pixel_addr registered to rgb_pixel valid, 1..4
//  COLORKEY  12'hF0F transparent colour (SPRITE_COLORKEY_EN only)
// PORTS
//  clk         in   1                  pixel clock
//  rst         in   1                  synchronous reset, active-high
//  xpos        in   12                 requested sprite left column
//  ypos        in   12                 requested sprite top row
//  spr_en      in   1                  requested sprite visibility
//  pixel_addr  out  ADDR_Y_W+ADDR_X_W  ROM address {row, col}
//  rgb_pixel   in   12                 ROM data, valid ROM_LAT cycles after pixel_addr
//  in          vga_if.in               upstream timing + rgb
//  out         vga_if.out              downstream timing + rgb
// BEHAVIOUR
//  - Reset: all out.* = 0, pixel_addr = 0, x_q = y_q = 0, en_q = 0, every delay-line stage = 0.
//  - Frame latch: vb_d <= in.vblnk every cycle.
//    When in.vblnk & !vb_d (rising edge), x_q <= xpos, y_q <= ypos, en_q <= spr_en.
//    Changes at any other time take effect from the next frame.
//  - Hit (stage 0, combinational on in.*), computed in 13 bits so xpos+SPR_W cannot wrap:
//    hit = en_q & !in.hblnk & !in.vblnk & x_q <= in.hcount < x_q+SPR_W & y_q <= in.vcount < y_q+SPR_H.
//    A sprite extending past the visible area is clipped by the blanking gate.
//    A sprite never wraps to column or row 0.
//  - Stage 1 (registered): pixel_addr <= hit ? {dy[ADDR_Y_W-1:0], dx[ADDR_X_W-1:0]} : 0,
//    where dx = in.hcount - x_q and dy = in.vcount - y_q. The hit flag is registered alongside.
//  - Delay line: hcount, vcount, hsync, vsync, hblnk, vblnk, rgb and hit pass through
//    1+ROM_LAT register stages, aligned with rgb_pixel.
//  - Output register: out.rgb <= hit_d ? rgb_pixel : rgb_d. Timing fields <= delayed copies.
//  - Total latency in.* -> out.* = ROM_LAT+2 cycles for every field.
//    Throughput is 1 pixel/clk with no stalls. No handshake: the ROM must meet ROM_LAT.
//  - Reset mid-frame: the pipeline flushes to 0 and en_q = 0.
//    The sprite stays hidden until the first vblnk rising edge after rst is released.
//  - Simultaneous vblnk edge and a position change: the value present in that same cycle is latched.
// CONFIGURATION
//  SPRITE_COLORKEY_EN defined:
//    out.rgb <= (hit_d & rgb_pixel != COLORKEY) ? rgb_pixel : rgb_d, so key-coloured
//    sprite pixels show the background.
//  SPRITE_COLORKEY_EN undefined: no compare logic; every hit pixel is opaque and COLORKEY is unused.
// TESTING
//  1 ROM_LAT=1, x_q=100, y_q=50, model ROM data = addr -> first sprite pixel at
//    (100,50) appears on out 3 clk later with rgb=0x000. Pixel (147,50) -> 0x02F.
//    Pixel (148,50) -> background.
//  2 xpos changed 100->200 while vcount=300 (active) -> rest of frame drawn at 100.
//    Next frame drawn at 200.
//  3 xpos=1010 at 1024 visible width -> columns 1010..1023 show sprite cols 0..13.
//    Column 0 of the next line is background; no wrap.
//  4 COLORKEY_EN, ROM returns 0xF0F at addr 5 -> out.rgb there = background; neighbours = sprite.
//  5 rst asserted 2 clk at vcount=60 -> all out.* = 0 the next cycle.
//    Sprite hidden for the remainder of that frame, then drawn again.
//  6 ROM_LAT=3 -> hsync/vsync/hcount and rgb all delayed exactly 5 clk; edges stay aligned.

Source files
------------

// File: rtl/draw_sprite_if.sv
// vga_if: one pixel of VGA timing plus colour, shared by every draw stage.
interface vga_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_sprite.sv
// draw_sprite: overlays a SPR_W x SPR_H image read from an external synchronous
// ROM onto the VGA stream at a per-frame latched position. Timing fields are
// delayed so they leave aligned with the ROM data; in.* -> out.* is ROM_LAT+2 clk.
// Optional feature macro: SPRITE_COLORKEY_EN (sprite pixels equal to COLORKEY
// are transparent and show the background).
module draw_sprite #(
  parameter int SPR_W    = 48,
  parameter int SPR_H    = 64,
  parameter int ADDR_X_W = 6,
  parameter int ADDR_Y_W = 6,
  parameter int ROM_LAT  = 1
`ifdef SPRITE_COLORKEY_EN
  , parameter logic [11:0] COLORKEY = 12'hF0F
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [11:0]                  xpos,
  input  logic [11:0]                  ypos,
  input  logic                         spr_en,
  output logic [ADDR_Y_W+ADDR_X_W-1:0] pixel_addr,
  input  logic [11:0]                  rgb_pixel,
  vga_if.in                            in,
  vga_if.out                           out
);
  localparam int AW     = ADDR_Y_W + ADDR_X_W;
  localparam int STAGES = ROM_LAT + 1;

  typedef struct packed {
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  typedef struct packed {
    vga_t v;
    logic hit;
  } tap_t;

  logic                vb_q, vb_d;
  logic [11:0]         x_q, x_d;
  logic [11:0]         y_q, y_d;
  logic                en_q, en_d;
  logic [AW-1:0]       addr_q, addr_d;
  tap_t [STAGES-1:0]   dl_q, dl_d;
  vga_t                out_q, out_d;

  logic                hit;
  logic [12:0]         hc13, vc13, x_end, y_end;
  logic [ADDR_X_W-1:0] dx;
  logic [ADDR_Y_W-1:0] dy;

  // Frame latch: position/enable only move on the rising edge of vblnk.
  always_comb begin
    vb_d = in.vblnk;
    x_d  = x_q;
    y_d  = y_q;
    en_d = en_q;
    if (in.vblnk && !vb_q) begin
      x_d  = xpos;
      y_d  = ypos;
      en_d = spr_en;
    end
  end

  // Hit test in 13 bits so the sprite's right/bottom edge never wraps to 0;
  // the blanking gate clips anything beyond the visible area.
  always_comb begin
    hc13   = {1'b0, in.hcount};
    vc13   = {1'b0, in.vcount};
    x_end  = {1'b0, x_q} + 13'(SPR_W);
    y_end  = {1'b0, y_q} + 13'(SPR_H);
    hit    = en_q & ~in.hblnk & ~in.vblnk &
             (hc13 >= {1'b0, x_q}) & (hc13 < x_end) &
             (vc13 >= {1'b0, y_q}) & (vc13 < y_end);
    dx     = ADDR_X_W'(in.hcount - x_q);
    dy     = ADDR_Y_W'(in.vcount - y_q);
    addr_d = hit ? {dy, dx} : '0;
  end

  // Delay line: stage 0 captures the input pixel alongside the ROM address,
  // the remaining ROM_LAT stages wait for rgb_pixel.
  always_comb begin
    dl_d[0].v.hcount = in.hcount;
    dl_d[0].v.vcount = in.vcount;
    dl_d[0].v.hsync  = in.hsync;
    dl_d[0].v.vsync  = in.vsync;
    dl_d[0].v.hblnk  = in.hblnk;
    dl_d[0].v.vblnk  = in.vblnk;
    dl_d[0].v.rgb    = in.rgb;
    dl_d[0].hit      = hit;
    for (int i = 1; i < STAGES; i++) dl_d[i] = dl_q[i-1];
  end

  // Output mux: ROM pixel wins over the background on a hit.
  always_comb begin
    out_d = dl_q[STAGES-1].v;
`ifdef SPRITE_COLORKEY_EN
    if (dl_q[STAGES-1].hit && (rgb_pixel != COLORKEY)) out_d.rgb = rgb_pixel;
`else
    if (dl_q[STAGES-1].hit) out_d.rgb = rgb_pixel;
`endif
  end

  // State registers; reset flushes the whole pipe and hides the sprite.
  always_ff @(posedge clk) begin
    if (rst) begin
      vb_q   <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      en_q   <= 1'b0;
      addr_q <= '0;
      dl_q   <= '0;
      out_q  <= '0;
    end else begin
      vb_q   <= vb_d;
      x_q    <= x_d;
      y_q    <= y_d;
      en_q   <= en_d;
      addr_q <= addr_d;
      dl_q   <= dl_d;
      out_q  <= out_d;
    end
  end

  assign pixel_addr = addr_q;
  assign out.hcount = out_q.hcount;
  assign out.vcount = out_q.vcount;
  assign out.hsync  = out_q.hsync;
  assign out.vsync  = out_q.vsync;
  assign out.hblnk  = out_q.hblnk;
  assign out.vblnk  = out_q.vblnk;
  assign out.rgb    = out_q.rgb;
endmodule
